// File: rtl/game_round_controller.sv
// Round sequencer for the binary counting game: LFSR target pick, display trigger,
// timed answer window, verdict hold, and score/lives/round bookkeeping.
module game_round_controller #(
    parameter int ANSWER_TIME = 5000,
    parameter int RESULT_TIME = 1000,
    parameter int MAX_ROUNDS  = 10,
    parameter int LIVES       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] answer,
    input  logic       sel_done,
    output logic       sel_trigger,
    output logic [7:0] target,
    output logic [2:0] phase,
    output logic [3:0] round,
    output logic [3:0] score,
    output logic [1:0] lives,
    output logic       result_valid,
    output logic       result_ok,
    output logic       timeout,
    output logic       game_over
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SHOW   = 3'd2;
    localparam logic [2:0] ST_ANSWER = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;
    localparam logic [2:0] ST_OVER   = 3'd5;

    localparam logic [12:0] ANS_LAST   = 13'(ANSWER_TIME - 1);
    localparam logic [12:0] RES_LAST   = 13'(RESULT_TIME - 1);
    localparam logic [3:0]  LAST_ROUND = 4'(MAX_ROUNDS);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    logic [2:0]  state_q,  state_d;
    logic [15:0] lfsr_q,   lfsr_d;
    logic [12:0] cnt_q,    cnt_d;
    logic [7:0]  target_q, target_d;
    logic [3:0]  round_q,  round_d;
    logic [3:0]  score_q,  score_d;
    logic [1:0]  lives_q,  lives_d;
    logic        trig_q,   trig_d;
    logic        rvalid_q, rvalid_d;
    logic        ok_q,     ok_d;
    logic        to_q,     to_d;
    logic        over_q,   over_d;
    logic        correct;

    assign correct = (answer == target_q);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        cnt_d    = cnt_q + 13'd1;
        target_d = target_q;
        round_d  = round_q;
        score_d  = score_q;
        lives_d  = lives_q;
        trig_d   = 1'b0;
        ok_d     = ok_q;
        to_d     = to_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_LOAD;
                    score_d = 4'd0;
                    lives_d = LIVES_INIT;
                    round_d = 4'd0;
                    ok_d    = 1'b0;
                    to_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                target_d = lfsr_q[7:0];
                round_d  = round_q + 4'd1;
                trig_d   = 1'b1;
                state_d  = ST_SHOW;
            end
            ST_SHOW: begin
                if (sel_done) state_d = ST_ANSWER;
            end
            ST_ANSWER: begin
                // A submit on the final window cycle still gets judged.
                if (submit || cnt_q == ANS_LAST) begin
                    state_d = ST_RESULT;
                    ok_d    = submit && correct;
                    to_d    = !submit;
                    if (submit && correct)
                        score_d = (score_q == 4'd15) ? score_q : score_q + 4'd1;
                    else
                        lives_d = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
                end
            end
            ST_RESULT: begin
                if (cnt_q == RES_LAST)
                    state_d = (lives_q == 2'd0 || round_q == LAST_ROUND) ? ST_OVER : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = 13'd0;
        rvalid_d = (state_d == ST_RESULT);
        over_d   = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= LFSR_SEED;
            cnt_q    <= 13'd0;
            target_q <= 8'd0;
            round_q  <= 4'd0;
            score_q  <= 4'd0;
            lives_q  <= LIVES_INIT;
            trig_q   <= 1'b0;
            rvalid_q <= 1'b0;
            ok_q     <= 1'b0;
            to_q     <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            round_q  <= round_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            trig_q   <= trig_d;
            rvalid_q <= rvalid_d;
            ok_q     <= ok_d;
            to_q     <= to_d;
            over_q   <= over_d;
        end
    end

    assign sel_trigger  = trig_q;
    assign target       = target_q;
    assign phase        = state_q;
    assign round        = round_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign result_valid = rvalid_q;
    assign result_ok    = ok_q;
    assign timeout      = to_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller: two full games, timeout and late-submit
// windows, ignored strobes, and a mid-answer reset, against a reference LFSR.
module tb_game_round_controller;

    localparam int ANSWER_TIME = 5000;
    localparam int RESULT_TIME = 1000;
    localparam int MAX_ROUNDS  = 10;
    localparam int LIVES       = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [7:0] answer = 8'd0;
    logic       sel_done = 1'b0;
    logic       sel_trigger;
    logic [7:0] target;
    logic [2:0] phase;
    logic [3:0] round;
    logic [3:0] score;
    logic [1:0] lives;
    logic       result_valid;
    logic       result_ok;
    logic       timeout;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int exp_score = 0;
    int exp_lives = LIVES;
    int exp_round = 0;
    logic [7:0]  last_t = 8'd0;
    logic [15:0] m_lfsr = 16'hACE1;

    game_round_controller #(
        .ANSWER_TIME(ANSWER_TIME),
        .RESULT_TIME(RESULT_TIME),
        .MAX_ROUNDS (MAX_ROUNDS),
        .LIVES      (LIVES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .submit      (submit),
        .answer      (answer),
        .sel_done    (sel_done),
        .sel_trigger (sel_trigger),
        .target      (target),
        .phase       (phase),
        .round       (round),
        .score       (score),
        .lives       (lives),
        .result_valid(result_valid),
        .result_ok   (result_ok),
        .timeout     (timeout),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, advancing on every non-reset edge.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_trig"}, sel_trigger, 0);
        check({tag, "_target"}, target, 0);
        check({tag, "_round"}, round, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_lives"}, lives, LIVES);
        check({tag, "_flags"}, {result_valid, result_ok, timeout, game_over}, 0);
    endtask

    // mode: 0 correct, 1 wrong, 2 timeout, 3 correct submit on last window cycle
    task automatic run_round(input int mode);
        logic [7:0] t;
        int n;
        logic ok;
        check("load_phase", phase, 1);
        t = m_lfsr[7:0];
        step();
        exp_round++;
        last_t = t;
        check("show_phase", phase, 2);
        check("trigger_first", sel_trigger, 1);
        check("target", target, t);
        check("round", round, exp_round);
        step();
        check("trigger_once", sel_trigger, 0);
        submit = 1'b1; start = 1'b1;
        step();
        submit = 1'b0; start = 1'b0;
        check("show_ignores", phase, 2);
        sel_done = 1'b1;
        step();
        sel_done = 1'b0;
        check("answer_phase", phase, 3);
        check("rv_low_in_answer", result_valid, 0);
        case (mode)
            0, 1: begin
                answer = (mode == 0) ? t : ~t;
                submit = 1'b1;
                step();
                submit = 1'b0;
            end
            2: begin
                n = 0;
                while (phase == 3'd3 && n < ANSWER_TIME + 100) begin
                    step();
                    n++;
                end
                check("timeout_len", n, ANSWER_TIME);
            end
            default: begin
                repeat (ANSWER_TIME - 1) step();
                check("late_still_answer", phase, 3);
                answer = t;
                submit = 1'b1;
                step();
                submit = 1'b0;
            end
        endcase
        ok = (mode == 0 || mode == 3);
        if (ok) begin
            if (exp_score < 15) exp_score++;
        end else if (exp_lives > 0) begin
            exp_lives--;
        end
        check("result_phase", phase, 4);
        check("result_valid", result_valid, 1);
        check("result_ok", result_ok, ok);
        check("timeout_flag", timeout, (mode == 2));
        check("score", score, exp_score);
        check("lives", lives, exp_lives);
        n = 1;
        while (n < RESULT_TIME + 100) begin
            step();
            if (result_valid !== 1'b1) break;
            n++;
        end
        check("result_len", n, RESULT_TIME);
        check("after_result", phase, (exp_lives == 0 || exp_round == MAX_ROUNDS) ? 5 : 1);
    endtask

    initial begin
        repeat (3) step();
        check_reset_state("reset");
        rst = 1'b0;
        step();
        sel_done = 1'b1; submit = 1'b1;
        step();
        sel_done = 1'b0; submit = 1'b0;
        check("idle_ignores", phase, 0);
        check("idle_no_trig", sel_trigger, 0);
        repeat (2) step();

        // Game 1: correct, wrong, timeout, late-correct, wrong -> out of lives.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_load", phase, 1);
        check("start_no_trig", sel_trigger, 0);
        run_round(0);
        run_round(1);
        run_round(2);
        run_round(3);
        run_round(1);
        repeat (5) step();
        check("over_phase", phase, 5);
        check("over_flag", game_over, 1);
        check("over_score", score, 2);
        check("over_lives", lives, 0);
        check("over_round", round, 5);
        check("over_target", target, last_t);
        check("over_rv_low", result_valid, 0);

        // Game 2: restart from OVER, ten correct rounds.
        start = 1'b1;
        step();
        start = 1'b0;
        exp_score = 0; exp_lives = LIVES; exp_round = 0;
        check("restart_phase", phase, 1);
        check("restart_score", score, 0);
        check("restart_lives", lives, LIVES);
        check("restart_round", round, 0);
        check("restart_flags", {game_over, result_ok, timeout}, 0);
        repeat (MAX_ROUNDS) run_round(0);
        step();
        check("g2_over_phase", phase, 5);
        check("g2_over_flag", game_over, 1);
        check("g2_score", score, 10);
        check("g2_round", round, 10);
        check("g2_lives", lives, LIVES);

        // Reset in the middle of an answer window.
        start = 1'b1;
        step();
        start = 1'b0;
        check("g3_load", phase, 1);
        step();
        check("g3_show", phase, 2);
        sel_done = 1'b1;
        step();
        sel_done = 1'b0;
        repeat (10) step();
        check("g3_answer", phase, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("midreset");
        step();
        check("post_reset_idle", phase, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
